// File: rtl/gf_pow_seq.sv
// gf_pow_seq -- constant-time exponentiation y = x^e in GF(2^M).
//
// A single combinational GF(2^M) multiplier is reused by a left-to-right
// square-and-multiply sequencer. Every exponent bit costs exactly one square
// and one multiply. The multiply always happens, by x when the bit is set and
// by 1 when it is clear. Latency is therefore 2*EW cycles for every operand.
//
// Parameters
//   M     field width in bits
//   POLY  reduction polynomial, M+1 bits with the MSB set
//   EW    exponent width in bits (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   x/e operand pair valid
//   in_ready   block can accept an operand pair (IDLE only)
//   x          base, M bits
//   e          exponent, EW bits, unsigned
//   out_valid  y holds a finished result
//   out_ready  consumer takes y
//   y          result x^e, M bits (0 when no result is held)
//   busy       high while computing or holding a result
//   inv        present only when GF_POW_INV_EN is defined. When it is 1 at
//              acceptance, the exponent is replaced by 2^M-2, which gives x^-1.
//
// Optional feature macro: GF_POW_INV_EN

module gf_pow_seq #(
   parameter int             M    = 8,
   parameter logic [M:0]     POLY = 9'h11B,
   parameter int             EW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [M-1:0]  x,
   input  logic [EW-1:0] e,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [M-1:0]  y,
`ifdef GF_POW_INV_EN
   input  logic          inv,
`endif
   output logic          busy
);

   localparam int             CW      = $clog2(2 * EW) + 1;
   localparam logic [CW-1:0]  LAST_OP = CW'(2 * EW - 1);
   localparam logic [M-1:0]   ONE     = M'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      SQR = 1'b0,
      MUL = 1'b1
   } phase_t;

   state_t          state_r;
   phase_t          phase_r;
   logic [CW-1:0]   cnt_r;
   logic [M-1:0]    acc_r;
   logic [M-1:0]    x_r;
   logic [EW-1:0]   e_r;      // shifted left after each multiply; MSB is the current bit
   logic [M-1:0]    op_b_s;
   logic [M-1:0]    prod_s;
   logic [EW-1:0]   e_load_s;

   // GF(2^M) product with reduction folded into each shift step, MSB of b first.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] p;
      p = {M{1'b0}};
      for (int i = M - 1; i >= 0; i--) begin
         if (p[M-1]) begin
            p = (p << 1) ^ POLY[M-1:0];
         end else begin
            p = p << 1;
         end
         if (b[i]) begin
            p = p ^ a;
         end else begin
            p = p;
         end
      end
      return p;
   endfunction

`ifdef GF_POW_INV_EN
   localparam logic [EW-1:0] INV_EXP = EW'((64'd1 << M) - 64'd2);

   generate
      if (EW < M) begin : g_ew_check
         $error("gf_pow_seq: GF_POW_INV_EN requires EW >= M");
      end
   endgenerate

   // Exponent captured at acceptance: the inversion exponent overrides e.
   always_comb begin
      if (inv) begin
         e_load_s = INV_EXP;
      end else begin
         e_load_s = e;
      end
   end
`else
   // Exponent captured at acceptance.
   always_comb begin
      e_load_s = e;
   end
`endif

   // Second multiplier operand: acc for a square, x or 1 for a multiply step.
   always_comb begin
      if (phase_r == SQR) begin
         op_b_s = acc_r;
      end else if (e_r[EW-1]) begin
         op_b_s = x_r;
      end else begin
         op_b_s = ONE;
      end
   end

   // The single shared multiplier.
   always_comb begin
      prod_s = gf_mul(acc_r, op_b_s);
   end

   // Sequencer: accept, run 2*EW operations, hold the result until it is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         phase_r   <= SQR;
         cnt_r     <= {CW{1'b0}};
         acc_r     <= ONE;
         x_r       <= {M{1'b0}};
         e_r       <= {EW{1'b0}};
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         y         <= {M{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  x_r      <= x;
                  e_r      <= e_load_s;
                  acc_r    <= ONE;
                  cnt_r    <= {CW{1'b0}};
                  phase_r  <= SQR;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_r  <= RUN;
               end
            end
            RUN: begin
               acc_r <= prod_s;
               cnt_r <= cnt_r + CW'(1);
               if (phase_r == SQR) begin
                  phase_r <= MUL;
               end else begin
                  phase_r <= SQR;
                  e_r     <= e_r << 1;
               end
               if (cnt_r == LAST_OP) begin
                  y         <= prod_s;
                  out_valid <= 1'b1;
                  state_r   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  y         <= {M{1'b0}};
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               phase_r   <= SQR;
               cnt_r     <= {CW{1'b0}};
               acc_r     <= ONE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               y         <= {M{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf_pow_seq.sv
// tb_gf_pow_seq -- directed bench for gf_pow_seq (M=8, POLY=11B, EW=8).
// Reference results come from long-hand polynomial arithmetic in GF(2^8).
// Powers are formed by repeated multiplication. A scoreboard queue holds the
// expected result of every accepted operation.

module tb_gf_pow_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] x = 8'h00;
   logic [7:0] e = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] y;
   logic       busy;
   logic       inv_drv = 1'b0;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;
   logic [7:0] exp_q[$];

   gf_pow_seq #(.M(8), .POLY(9'h11B), .EW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .e         (e),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
`ifdef GF_POW_INV_EN
      .inv       (inv_drv),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #500us;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      chk_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   // Full 16-bit carry-less product, then long division by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod = 16'h0000;
      for (int i = 0; i < 8; i++)
         if (b[i]) prod = prod ^ (16'(a) << i);
      for (int k = 15; k >= 8; k--)
         if (prod[k]) prod = prod ^ (16'h011B << (k - 8));
      return prod[7:0];
   endfunction

   function automatic logic [7:0] m_pow(input logic [7:0] b, input int n);
      logic [7:0] r = 8'h01;
      for (int i = 0; i < n; i++) r = m_mul(r, b);
      return r;
   endfunction

   // Compare process: whenever a result is presented it must equal the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         check("pending_result", exp_q.size(), 1);
         if (exp_q.size() > 0) check("y_vs_model", y, exp_q[0]);
      end
   end

   task automatic run_op(input logic [7:0] xv, input logic [7:0] ev, input bit inv_v,
                         input bit lit_en, input logic [7:0] lit, input int stall,
                         output int acc_cyc);
      int n;
      logic [7:0] held;
      acc_cyc = 0;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_wait", in_ready, 1);
      if (!in_ready) return;
      x = xv; e = ev; inv_drv = inv_v; in_valid = 1'b1;
      @(posedge clk);
      acc_cyc = cyc;
      exp_q.push_back(inv_v ? m_pow(xv, 254) : m_pow(xv, int'(ev)));
      #1;
      in_valid = 1'b0;
      x = 8'($urandom); e = 8'($urandom); inv_drv = 1'($urandom);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!out_valid && n < 40);
      check("latency", n, 16);
      if (lit_en) begin
         if (!inv_v) check("model_pin", m_pow(xv, int'(ev)), lit);
         check("literal", y, lit);
      end
      held = y;
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1; x = 8'($urandom); e = 8'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("stall_out_valid", out_valid, 1);
         check("stall_y", y, held);
         check("stall_in_ready", in_ready, 0);
         check("stall_busy", busy, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check("post_out_valid", out_valid, 0);
      check("post_y", y, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
   endtask

   initial begin
      int a1, a2, dummy;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_y", y, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("idle_in_ready", in_ready, 1);

      // Hand-computed cubes, then back-to-back to measure throughput.
      run_op(8'h02, 8'h03, 1'b0, 1'b1, 8'h08, 0, a1);
      run_op(8'h08, 8'h03, 1'b0, 1'b1, 8'h36, 0, a2);
      check("throughput", a2 - a1, 18);
      run_op(8'h03, 8'h03, 1'b0, 1'b1, 8'h0F, 0, dummy);
      run_op(8'h04, 8'h03, 1'b0, 1'b1, 8'h40, 0, dummy);

      // Boundary exponents and bases.
      run_op(8'h53, 8'hFE, 1'b0, 1'b1, 8'hCA, 0, dummy);
      run_op(8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 0, dummy);
      run_op(8'h53, 8'h00, 1'b0, 1'b1, 8'h01, 0, dummy);
      run_op(8'hFF, 8'h00, 1'b0, 1'b1, 8'h01, 0, dummy);
      run_op(8'h00, 8'h05, 1'b0, 1'b1, 8'h00, 0, dummy);
      run_op(8'hB7, 8'hFF, 1'b0, 1'b1, 8'h01, 0, dummy);
      run_op(8'h02, 8'h80, 1'b0, 1'b0, 8'h00, 0, dummy);
      run_op(8'hC5, 8'hAA, 1'b0, 1'b0, 8'h00, 0, dummy);
      run_op(8'h1F, 8'h01, 1'b0, 1'b0, 8'h00, 0, dummy);

      // Consumer stall of 10 cycles with in_valid pulses that must be ignored.
      run_op(8'h02, 8'h03, 1'b0, 1'b1, 8'h08, 10, dummy);
      repeat (20) begin
         @(posedge clk); #1;
         check("no_spurious_op", busy, 0);
      end

`ifdef GF_POW_INV_EN
      run_op(8'h53, 8'h00, 1'b1, 1'b1, 8'hCA, 0, dummy);
      run_op(8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 0, dummy);
      run_op(8'h02, 8'h03, 1'b0, 1'b1, 8'h08, 0, dummy);
`endif

      // Reset in the middle of a computation.
      x = 8'h02; e = 8'h03; inv_drv = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_y", y, 0);
      exp_q.delete();
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("abort_idle_in_ready", in_ready, 1);
      run_op(8'h02, 8'h03, 1'b0, 1'b1, 8'h08, 0, dummy);

      // Full sweep of x with e=3 against the cube table.
      for (int xi = 0; xi < 256; xi++)
         run_op(8'(xi), 8'h03, 1'b0, 1'b0, 8'h00, 0, dummy);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
